// File: rtl/lms_mu_if.sv
// lms_mu_if: control, config, error stream and status between registers, filter and scheduler
interface lms_mu_if;
    logic               start;
    logic               stop;
    logic               e_valid;
    logic signed [32:0] e_in;
    logic [7:0]         mu_start_in;
    logic [7:0]         mu_final_in;
    logic [31:0]        thr_conv_in;
    logic [31:0]        thr_div_in;
    logic [7:0]         mu_out;
    logic               filt_rst_n;
    logic               busy;
    logic               converged;
    logic               fail;
    logic               win_done;
    logic [2:0]         state;

    modport master (
        output start, stop, e_valid, e_in, mu_start_in, mu_final_in, thr_conv_in, thr_div_in,
        input  mu_out, filt_rst_n, busy, converged, fail, win_done, state
    );

    modport slave (
        input  start, stop, e_valid, e_in, mu_start_in, mu_final_in, thr_conv_in, thr_div_in,
        output mu_out, filt_rst_n, busy, converged, fail, win_done, state
    );
endinterface

// File: rtl/lms_mu_scheduler.sv
// lms_mu_scheduler: step-size scheduler and run sequencer for the 16-tap LMS FIR
module lms_mu_scheduler #(
    parameter int WIN_LOG2  = 6,
    parameter int FLUSH_LEN = 16,
    parameter int MAX_WIN   = 255
) (
    input logic     clk,
    input logic     reset,
    lms_mu_if.slave bus
);
    localparam int AW  = 33 + WIN_LOG2;
    localparam int FCW = $clog2(FLUSH_LEN + 1);
    localparam int TWW = $clog2(MAX_WIN + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);
    localparam logic [TWW-1:0] WIN_LIMIT  = TWW'(MAX_WIN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_TRAIN = 3'd2,
        S_TRACK = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mu_q, mu_d;
    logic [7:0]      mu_start_q, mu_start_d;
    logic [7:0]      mu_final_q, mu_final_d;
    logic [31:0]     thr_conv_q, thr_conv_d;
    logic [31:0]     thr_div_q, thr_div_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [TWW-1:0]  twin_q, twin_d;
    logic [TWW-1:0]  twin_inc;
    logic            fail_q, fail_d;
    logic            win_done_q, win_done_d;
    logic            filt_q, filt_d;
    logic [32:0]     mag;
    logic [AW-1:0]   sum;
    logic [32:0]     mean;
    logic            win_end;
    logic            conv_ok;
    logic            div_hit;

    // Window arithmetic: the completing sample is folded into the mean it closes
    always_comb begin
        mag      = bus.e_in[32] ? $unsigned(-bus.e_in) : $unsigned(bus.e_in);
        sum      = acc_q + AW'(mag);
        mean     = sum[AW-1:WIN_LOG2];
        win_end  = (state_q == S_TRAIN || state_q == S_TRACK) && bus.e_valid && (cnt_q == '1);
        conv_ok  = mean <= {1'b0, thr_conv_q};
        div_hit  = mean > {1'b0, thr_div_q};
        twin_inc = twin_q + 1'b1;
    end

    // Next-state, step and counter logic; stop outranks window evaluation, which outranks start
    always_comb begin
        state_d    = state_q;
        mu_d       = mu_q;
        mu_start_d = mu_start_q;
        mu_final_d = mu_final_q;
        thr_conv_d = thr_conv_q;
        thr_div_d  = thr_div_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        twin_d     = twin_q;
        fail_d     = fail_q;
        win_done_d = 1'b0;
        if (bus.stop) begin
            state_d = S_IDLE;
            mu_d    = mu_start_q;
            fail_d  = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            fcnt_d  = '0;
            twin_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_FAIL: begin
                    if (bus.start) begin
                        state_d    = S_FLUSH;
                        mu_start_d = bus.mu_start_in;
                        mu_final_d = (bus.mu_final_in < bus.mu_start_in) ? bus.mu_start_in : bus.mu_final_in;
                        thr_conv_d = bus.thr_conv_in;
                        thr_div_d  = bus.thr_div_in;
                        mu_d       = bus.mu_start_in;
                        fail_d     = 1'b0;
                        acc_d      = '0;
                        cnt_d      = '0;
                        fcnt_d     = '0;
                        twin_d     = '0;
                    end
                end
                S_FLUSH: begin
                    if (bus.e_valid) begin
                        fcnt_d  = (fcnt_q == FLUSH_LAST) ? '0 : fcnt_q + 1'b1;
                        state_d = (fcnt_q == FLUSH_LAST) ? S_TRAIN : S_FLUSH;
                        acc_d   = '0;
                        cnt_d   = '0;
                        twin_d  = '0;
                    end
                end
                S_TRAIN, S_TRACK: begin
                    if (bus.e_valid) begin
                        acc_d = win_end ? '0 : sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (win_end) begin
                        win_done_d = 1'b1;
                        if (state_q == S_TRAIN) begin
                            twin_d = twin_inc;
                            if (conv_ok && mu_q == mu_final_q) begin
                                state_d = S_TRACK;
                            end else begin
                                mu_d    = conv_ok ? mu_q + 8'd1 : mu_q;
                                state_d = (twin_inc == WIN_LIMIT) ? S_FAIL : S_TRAIN;
                                fail_d  = (twin_inc == WIN_LIMIT);
                            end
                        end else if (div_hit) begin
                            state_d = S_TRAIN;
                            mu_d    = mu_start_q;
                            twin_d  = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        filt_d = (state_d == S_FLUSH || state_d == S_TRAIN || state_d == S_TRACK);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mu_q       <= '0;
            mu_start_q <= '0;
            mu_final_q <= '0;
            thr_conv_q <= '0;
            thr_div_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            twin_q     <= '0;
            fail_q     <= 1'b0;
            win_done_q <= 1'b0;
            filt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mu_q       <= mu_d;
            mu_start_q <= mu_start_d;
            mu_final_q <= mu_final_d;
            thr_conv_q <= thr_conv_d;
            thr_div_q  <= thr_div_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            twin_q     <= twin_d;
            fail_q     <= fail_d;
            win_done_q <= win_done_d;
            filt_q     <= filt_d;
        end
    end

    assign bus.mu_out     = mu_q;
    assign bus.filt_rst_n = filt_q;
    assign bus.busy       = (state_q == S_FLUSH || state_q == S_TRAIN || state_q == S_TRACK);
    assign bus.converged  = (state_q == S_TRACK);
    assign bus.fail       = fail_q;
    assign bus.win_done   = win_done_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_lms_mu_scheduler.sv
// tb_lms_mu_scheduler: directed and randomized checks against a window-list reference model
module tb_lms_mu_scheduler;
    localparam int WL  = 6;
    localparam int WIN = 1 << WL;
    localparam int FL  = 16;
    localparam int MW  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lms_mu_if bus ();

    lms_mu_scheduler #(.WIN_LOG2(WL), .FLUSH_LEN(FL), .MAX_WIN(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         m_state;
    int         m_flush;
    int         m_wins;
    logic [7:0] m_mu;
    logic [7:0] c_ms;
    logic [7:0] c_mf;
    longint     c_tc;
    longint     c_td;
    bit         m_fail;
    bit         m_wd;
    longint     win_q[$];

    // Reference: run phases from the rules, window mean from a stored list of magnitudes
    task automatic model_step();
        longint ev;
        longint mag;
        longint total;
        longint mean;
        m_wd = 1'b0;
        if (!reset) begin
            m_state = 0; m_mu = 0; c_ms = 0; c_mf = 0; c_tc = 0; c_td = 0;
            m_fail = 0; m_flush = 0; m_wins = 0;
            win_q.delete();
            return;
        end
        if (bus.stop) begin
            m_state = 0; m_mu = c_ms; m_fail = 0; m_flush = 0;
            win_q.delete();
            return;
        end
        if ((m_state == 0 || m_state == 4) && bus.start) begin
            c_ms = bus.mu_start_in;
            c_mf = (bus.mu_final_in < bus.mu_start_in) ? bus.mu_start_in : bus.mu_final_in;
            c_tc = longint'(bus.thr_conv_in);
            c_td = longint'(bus.thr_div_in);
            m_mu = bus.mu_start_in; m_fail = 0; m_flush = 0; m_state = 1;
            win_q.delete();
            return;
        end
        if (!bus.e_valid || m_state == 0 || m_state == 4) return;
        ev  = longint'($signed(bus.e_in));
        mag = (ev < 0) ? -ev : ev;
        if (m_state == 1) begin
            m_flush++;
            if (m_flush == FL) begin
                m_state = 2; m_wins = 0; m_flush = 0;
                win_q.delete();
            end
            return;
        end
        win_q.push_back(mag);
        if (win_q.size() < WIN) return;
        total = 0;
        foreach (win_q[i]) total += win_q[i];
        mean = total / WIN;
        win_q.delete();
        m_wd = 1'b1;
        if (m_state == 2) begin
            m_wins++;
            if (mean <= c_tc && m_mu == c_mf) m_state = 3;
            else begin
                if (mean <= c_tc) m_mu = m_mu + 8'd1;
                if (m_wins == MW) begin
                    m_state = 4; m_fail = 1'b1;
                end
            end
        end else if (mean > c_td) begin
            m_state = 2; m_mu = c_ms; m_wins = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the current inputs, then compare every output after the edge
    task automatic cyc();
        bit busy_exp;
        model_step();
        @(posedge clk);
        #1;
        busy_exp = (m_state >= 1 && m_state <= 3);
        chk("state", bus.state, m_state);
        chk("mu_out", bus.mu_out, m_mu);
        chk("filt_rst_n", bus.filt_rst_n, busy_exp);
        chk("busy", bus.busy, busy_exp);
        chk("converged", bus.converged, m_state == 3);
        chk("fail", bus.fail, m_fail);
        chk("win_done", bus.win_done, m_wd);
    endtask

    task automatic pulse_start(input logic [7:0] ms, input logic [7:0] mf, input logic [31:0] tc, input logic [31:0] td);
        bus.mu_start_in = ms;
        bus.mu_final_in = mf;
        bus.thr_conv_in = tc;
        bus.thr_div_in  = td;
        bus.start   = 1'b1;
        bus.e_valid = 1'b0;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop    = 1'b1;
        bus.e_valid = 1'b0;
        cyc();
        bus.stop = 1'b0;
    endtask

    // sgn: 0 positive, 1 negative, 2 random sign
    task automatic run(input int n, input longint lo, input longint hi, input int vpct, input int sgn);
        longint mag;
        bit     neg;
        for (int i = 0; i < n; i++) begin
            mag = lo + longint'($urandom_range(32'(hi - lo)));
            neg = (sgn == 1) || (sgn == 2 && $urandom_range(1) == 1);
            bus.e_valid = ($urandom_range(99) < vpct);
            bus.e_in    = 33'(neg ? -mag : mag);
            cyc();
        end
    endtask

    initial begin
        int vc;
        bus.start = 0; bus.stop = 0; bus.e_valid = 0; bus.e_in = '0;
        bus.mu_start_in = 0; bus.mu_final_in = 0; bus.thr_conv_in = 0; bus.thr_div_in = 0;
        repeat (3) cyc();
        chk("rst_state", bus.state, 0);
        chk("rst_mu", bus.mu_out, 0);
        chk("rst_filt", bus.filt_rst_n, 0);
        reset = 1'b1;
        cyc();

        pulse_start(8'd4, 8'd6, 32'd100, 32'd1000);
        chk("t1_flush", bus.state, 1);
        chk("t1_filt", bus.filt_rst_n, 1);
        run(FL + 3 * WIN - 1, 50, 50, 100, 2);
        chk("t1_pre_track", bus.state, 2);
        run(1, 50, 50, 100, 2);
        chk("t1_track", bus.state, 3);
        chk("t1_conv", bus.converged, 1);
        chk("t1_mu", bus.mu_out, 6);

        pulse_stop();
        pulse_start(8'd4, 8'd6, 32'd100, 32'd1000);
        run(FL + 3 * WIN, 200, 200, 100, 2);
        chk("t2_state", bus.state, 4);
        chk("t2_fail", bus.fail, 1);
        chk("t2_filt", bus.filt_rst_n, 0);
        chk("t2_mu", bus.mu_out, 4);
        run(20, 0, 300, 100, 2);
        chk("t2_hold", bus.state, 4);
        pulse_start(8'd4, 8'd6, 32'd100, 32'd1000);
        chk("t2_clear", bus.fail, 0);

        run(FL + 3 * WIN, 50, 50, 100, 2);
        chk("t3_track", bus.state, 3);
        run(WIN, 2000, 2000, 100, 1);
        chk("t3_state", bus.state, 2);
        chk("t3_mu", bus.mu_out, 4);
        chk("t3_conv", bus.converged, 0);
        chk("t3_filt", bus.filt_rst_n, 1);

        pulse_stop();
        pulse_start(8'd4, 8'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(FL, 0, 0, 100, 0);
        run(WIN, 64'h1_0000_0000, 64'h1_0000_0000, 100, 1);
        chk("t4_win", bus.win_done, 1);
        chk("t4_mu", bus.mu_out, 4);
        chk("t4_state", bus.state, 2);

        run(WIN - 1, 0, 0, 100, 0);
        bus.stop = 1; bus.start = 1; bus.e_valid = 1; bus.e_in = '0;
        cyc();
        bus.stop = 0; bus.start = 0;
        chk("t5_state", bus.state, 0);
        chk("t5_win", bus.win_done, 0);
        chk("t5_mu", bus.mu_out, 4);

        pulse_start(8'd7, 8'd3, 32'd100, 32'd1000);
        run(FL, 0, 0, 100, 0);
        vc = 0;
        for (int i = 0; i < 400 && vc < WIN - 1; i++) begin
            bus.e_valid = 1'($urandom_range(1));
            bus.e_in    = '0;
            vc += int'(bus.e_valid);
            cyc();
        end
        bus.e_valid = 0;
        cyc();
        chk("t6_open", bus.state, 2);
        bus.e_valid = 1;
        cyc();
        chk("t6_track", bus.state, 3);
        chk("t6_mu", bus.mu_out, 7);
        chk("t6_win", bus.win_done, 1);

        run(30, 0, 300, 80, 2);
        reset = 1'b0;
        cyc();
        chk("rst_mid_state", bus.state, 0);
        chk("rst_mid_mu", bus.mu_out, 0);
        reset = 1'b1;
        run(20, 0, 300, 100, 2);
        chk("rst_mid_idle", bus.state, 0);

        for (int r = 0; r < 8; r++) begin
            pulse_start(8'($urandom_range(8)), 8'($urandom_range(10)),
                        32'($urandom_range(150, 50)), 32'($urandom_range(400, 100)));
            for (int i = 0; i < 450; i++) begin
                bus.stop        = ($urandom_range(199) == 0);
                bus.start       = ($urandom_range(99) == 0);
                bus.mu_start_in = 8'($urandom_range(8));
                bus.mu_final_in = 8'($urandom_range(10));
                bus.thr_conv_in = 32'($urandom_range(150, 50));
                bus.thr_div_in  = 32'($urandom_range(400, 100));
                run(1, 0, 200, 70, 2);
            end
            bus.start = 0;
            bus.stop  = 0;
            pulse_stop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lms_mu_scheduler.md
# lms_mu_scheduler

Step-size scheduler and sequencer for the 16-tap LMS adaptive FIR. It holds the filter in reset until a run is started, then releases it and lets the delay line fill. During training it measures the mean absolute error over fixed windows and raises the `mu` shift (smaller step) one notch per converged window until it reaches the final value. It then tracks, and re-enters training at the start step if the filter diverges. It sits between the control/config registers and the filter's `mu_in`, `reset` and `e_out` ports.

## Interface
- `WIN_LOG2`, default 6: window length is 2^WIN_LOG2 valid error samples.
- `FLUSH_LEN`, default 16: valid samples ignored after filter release (fills the delay line).
- `MAX_WIN`, default 255: training windows allowed before failure.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse; begins a run from IDLE or FAIL.
- `stop`  in  1  pulse; aborts to IDLE from any state.
- `e_valid`  in  1  qualifies `e_in`; one error sample per high cycle.
- `e_in`  in  33 signed  filter error (`e_out`).
- `mu_start_in`  in  8  initial shift; latched on accepted `start`.
- `mu_final_in`  in  8  final shift; latched on accepted `start`.
- `thr_conv_in`  in  32 unsigned  convergence threshold on window mean |e|; latched on `start`.
- `thr_div_in`  in  32 unsigned  divergence threshold on window mean |e|; latched on `start`.
- `mu_out`  out  8  registered shift to filter `mu_in`.
- `filt_rst_n`  out  1  registered active-low reset to filter.
- `busy`  out  1  state is FLUSH, TRAIN or TRACK.
- `converged`  out  1  state is TRACK.
- `fail`  out  1  sticky training timeout; cleared by `start` or `stop`.
- `win_done`  out  1  one-cycle pulse at every evaluated window end.
- `state`  out  3  IDLE=0, FLUSH=1, TRAIN=2, TRACK=3, FAIL=4.

## Operation
- Magnitude: |e_in| as 33-bit unsigned. -2^32 maps to 2^32; no saturation needed.
- Accumulator: 33+WIN_LOG2 bits unsigned. It adds |e_in| on each `e_valid` in TRAIN and TRACK.
- Window mean: accumulator >> WIN_LOG2 (33 bits), compared against the zero-extended threshold.
- Sample counter: WIN_LOG2 bits, counts valid samples. The window ends on the valid sample that completes 2^WIN_LOG2 samples; that sample is included. Accumulator and counter then clear.
- Config latch: if `mu_final_in` < `mu_start_in`, the latched final value equals `mu_start_in`.
- IDLE: `filt_rst_n`=0; `mu_out` = latched start (0 after reset). On `start` → FLUSH, latch config, clear `fail`.
- FLUSH: `filt_rst_n`=1, `mu_out`=mu_start. Counts FLUSH_LEN valid samples, none accumulated, then → TRAIN with accumulator, window counter and training-window counter cleared.
- TRAIN, at window end:
  - mean <= thr_conv and `mu_out` == mu_final → TRACK.
  - mean <= thr_conv otherwise → `mu_out`+1, stay in TRAIN.
  - mean > thr_conv → `mu_out` unchanged.
  - Training-window counter increments on every window. When it reaches MAX_WIN without entering TRACK → FAIL.
- TRACK, at window end: mean > thr_div → TRAIN, `mu_out`=mu_start, training-window counter cleared. Coefficients are kept; the filter is not reset.
- FAIL: `filt_rst_n`=0, `fail`=1. `start` → FLUSH.
- Priority: `stop` > window-end evaluation > `start`. `start` is ignored in FLUSH, TRAIN and TRACK. `stop` in IDLE does nothing except clear `fail`.
- `e_valid` is ignored in IDLE and FAIL.

## Timing
- Reset values: `mu_out`=0, `filt_rst_n`=0, `busy`=0, `converged`=0, `fail`=0, `win_done`=0, `state`=IDLE. Counters, accumulator and latched config are 0.
- `start` in cycle N: `state`=FLUSH and `filt_rst_n`=1 in cycle N+1.
- Window end on sample in cycle N: `win_done`, the `mu_out` change and the state change are all visible in cycle N+1.
- `stop` in cycle N: IDLE and `filt_rst_n`=0 in N+1. The accumulator clears in N+1.
- Reset asserted mid-run: the next edge restores all reset values. No run resumes.
- `e_valid` may be high every cycle. There is no back-pressure.

## Test plan
1. Reset, then start with mu_start=4, mu_final=6, thr_conv=100, WIN_LOG2=6, FLUSH_LEN=16. Drive |e|=50 every cycle. → FLUSH for 16 samples. `mu_out` goes 4→5→6 at windows 1 and 2; TRACK after window 3 (cycle 16+192+1); `converged`=1.
2. Train with |e|=200, thr_conv=100, MAX_WIN=3. → `mu_out` stays 4; FAIL after the 3rd window; `fail`=1; `filt_rst_n`=0. A later `start` clears `fail`.
3. Reach TRACK (thr_div=1000), then drive e=-2000 for one window. → TRAIN, `mu_out`=4, `converged`=0, `filt_rst_n` stays 1.
4. Drive e=-2^32 for a full window with thr_conv=2^32-1. → mean=2^32 > thr, so no step and no overflow.
5. Assert `stop` in the same cycle as the window-completing sample, with `start` also high. → IDLE next cycle; no `win_done`; no `mu_out` change.
6. Start with mu_start=7, mu_final=3 and |e|=0. → TRACK after the first window; `mu_out`=7. Toggle `e_valid` 50% and check the window closes only after 64 valid samples.
